// File: rtl/panda_pcap_dma_fifo.sv
// Position-capture DMA buffer: FIFO with a registered output word, burst-threshold
// DMA request, sticky overflow, and the flush side of the arming FIFO-reset handshake.
module panda_pcap_dma_fifo #(
  parameter int unsigned DW           = 32,
  parameter int unsigned AW           = 10,
  parameter int unsigned BURST_LEN    = 256,
  parameter int unsigned FLUSH_CYCLES = 4
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          fifo_reset_i,
  output logic          fifo_ready_o,
  input  logic          dma_busy_i,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_ready_i,
  output logic          rd_valid_o,
  output logic [DW-1:0] rd_data_o,
  output logic [AW:0]   count_o,
  output logic          dma_req_o,
  output logic          overflow_o
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned HW    = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    FLUSH_WAIT,
    FLUSH_HOLD,
    READY
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;

  // Flush handshake: wait for DMA idle and request released, hold cleared, then serve.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      FLUSH_WAIT: begin
        hold_d = '0;
        if (!dma_busy_i && !fifo_reset_i) state_d = FLUSH_HOLD;
      end
      FLUSH_HOLD: begin
        if (fifo_reset_i) begin
          state_d = FLUSH_WAIT;
          hold_d  = '0;
        end else if (hold_q == HW'(FLUSH_CYCLES - 1)) begin
          state_d = READY;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      READY: begin
        if (fifo_reset_i) state_d = FLUSH_WAIT;
      end
      default: state_d = FLUSH_WAIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= FLUSH_WAIT;
      hold_q       <= '0;
      fifo_ready_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      fifo_ready_o <= (state_d == READY);
    end
  end

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] mem_cnt, count_d;
  logic          keep, full, wr_acc, rd_fire, load;

  // Buffer contents survive only while the block stays in READY across the edge.
  assign keep    = reset_n_i && (state_q == READY) && (state_d == READY);
  assign full    = (count_o == CW'(DEPTH));
  assign wr_acc  = keep && wr_en_i && !full;
  assign rd_fire = rd_valid_o && rd_ready_i;
  // Words still in the array, i.e. not yet moved into the output register.
  assign mem_cnt = count_o - CW'(rd_valid_o);
  assign load    = (mem_cnt != '0) && (!rd_valid_o || rd_fire);
  assign count_d = count_o + CW'(wr_acc) - CW'(rd_fire);

  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!keep) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      count_o    <= '0;
      dma_req_o  <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (load) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        rd_data_o <= mem[rd_ptr_q];
      end
      rd_valid_o <= load || (rd_valid_o && !rd_fire);
      count_o    <= count_d;
      dma_req_o  <= (count_d >= CW'(BURST_LEN));
      if (wr_en_i && full) overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_panda_pcap_dma_fifo.sv
// Bench for panda_pcap_dma_fifo: vector table for the flush/basic path, hand-written
// sequences for fill/overflow/wrap, busy flush, flush restart and mid-run reset.
module tb_panda_pcap_dma_fifo;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;
  localparam int BURST = 256;

  logic          clk = 1'b0;
  logic          reset_n, fifo_reset, dma_busy, wr_en, rd_ready;
  logic [DW-1:0] wr_data;
  logic          fifo_ready, rd_valid, dma_req, overflow;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb[$];

  panda_pcap_dma_fifo #(.DW(DW), .AW(AW), .BURST_LEN(BURST), .FLUSH_CYCLES(4)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .fifo_reset_i(fifo_reset), .fifo_ready_o(fifo_ready),
    .dma_busy_i(dma_busy), .wr_en_i(wr_en), .wr_data_i(wr_data), .rd_ready_i(rd_ready),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .count_o(count), .dma_req_o(dma_req),
    .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic fr, bsy, we, rr, acc;
    logic [DW-1:0] wd;
    logic er, ev, ereq, eovf;
    logic [DW-1:0] ed;
    int ec;
  } vec_t;

  function automatic vec_t mk(input logic fr, input logic bsy, input logic we,
                              input logic [DW-1:0] wd, input logic rr, input logic acc,
                              input logic er, input logic ev, input logic [DW-1:0] ed,
                              input int ec, input logic ereq, input logic eovf);
    vec_t v;
    v.fr = fr; v.bsy = bsy; v.we = we; v.wd = wd; v.rr = rr; v.acc = acc;
    v.er = er; v.ev = ev; v.ed = ed; v.ec = ec; v.ereq = ereq; v.eovf = eovf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard pops on every transfer seen before the edge, then advances one cycle.
  task automatic tick();
    logic [DW-1:0] e;
    if (rd_valid && rd_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got %0h expected no transfer", rd_data);
      end else begin
        e = sb.pop_front();
        chk("rd_data", 64'(rd_data), 64'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d, input bit acc);
    wr_en = 1'b1;
    wr_data = d;
    if (acc) sb.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ready"}, 64'(fifo_ready), 64'(0));
    chk({nm, "_valid"}, 64'(rd_valid), 64'(0));
    chk({nm, "_data"}, 64'(rd_data), 64'(0));
    chk({nm, "_count"}, 64'(count), 64'(0));
    chk({nm, "_req"}, 64'(dma_req), 64'(0));
    chk({nm, "_ovf"}, 64'(overflow), 64'(0));
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = mk(1, 1, 0, 0,     0, 0, 0, 0, 0,     0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0,     0, 0, 0, 0, 0,     0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0,     0, 0, 0, 0, 0,     0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0,     0, 0, 0, 0, 0,     0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0,     0, 0, 0, 0, 0,     0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0,     0, 0, 1, 0, 0,     0, 0, 0);
    vecs[6]  = mk(0, 0, 1, 'hA,   0, 1, 1, 0, 0,     1, 0, 0);
    vecs[7]  = mk(0, 0, 1, 'hB,   0, 1, 1, 1, 'hA,   2, 0, 0);
    vecs[8]  = mk(0, 0, 1, 'hC,   0, 1, 1, 1, 'hA,   3, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0,     1, 0, 1, 1, 'hB,   2, 0, 0);
    vecs[10] = mk(0, 0, 0, 0,     1, 0, 1, 1, 'hC,   1, 0, 0);
    vecs[11] = mk(0, 0, 0, 0,     1, 0, 1, 0, 0,     0, 0, 0);
    vecs[12] = mk(0, 0, 0, 0,     1, 0, 1, 0, 0,     0, 0, 0);

    reset_n = 1'b0; fifo_reset = 1'b0; dma_busy = 1'b0;
    wr_en = 1'b0; wr_data = '0; rd_ready = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    reset_n = 1'b1;

    // Flush handshake and basic three-word write/read
    foreach (vecs[i]) begin
      fifo_reset = vecs[i].fr;
      dma_busy   = vecs[i].bsy;
      wr_en      = vecs[i].we;
      wr_data    = vecs[i].wd;
      rd_ready   = vecs[i].rr;
      if (vecs[i].we && vecs[i].acc) sb.push_back(vecs[i].wd);
      tick();
      chk($sformatf("v%0d_ready", i), 64'(fifo_ready), 64'(vecs[i].er));
      chk($sformatf("v%0d_valid", i), 64'(rd_valid), 64'(vecs[i].ev));
      if (vecs[i].ev) chk($sformatf("v%0d_data", i), 64'(rd_data), 64'(vecs[i].ed));
      chk($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].ec));
      chk($sformatf("v%0d_req", i), 64'(dma_req), 64'(vecs[i].ereq));
      chk($sformatf("v%0d_ovf", i), 64'(overflow), 64'(vecs[i].eovf));
    end
    wr_en = 1'b0;
    rd_ready = 1'b0;

    // Fill to DEPTH (pointers start at 3, so this wraps), then overflow with a read
    for (int i = 0; i < DEPTH; i++) begin
      wr(DW'(i), 1'b1);
      chk("fill_count", 64'(count), 64'(i + 1));
      chk("fill_req", 64'(dma_req), 64'((i + 1) >= BURST));
    end
    chk("full_ovf", 64'(overflow), 64'(0));
    rd_ready = 1'b1;
    wr(32'hDEAD, 1'b0);
    chk("ovf_set", 64'(overflow), 64'(1));
    chk("ovf_count", 64'(count), 64'(DEPTH - 1));
    for (int k = 0; k < 2 * DEPTH && sb.size() > 0; k++) tick();
    chk("drain_done", 64'(sb.size()), 64'(0));
    rd_ready = 1'b0;
    chk("drain_count", 64'(count), 64'(0));
    chk("drain_valid", 64'(rd_valid), 64'(0));
    chk("drain_req", 64'(dma_req), 64'(0));
    chk("drain_ovf_sticky", 64'(overflow), 64'(1));

    // Flush while a DMA burst is in flight
    wr(32'h11, 1'b1);
    wr(32'h22, 1'b1);
    fifo_reset = 1'b1;
    dma_busy = 1'b1;
    tick();
    sb.delete();
    chk("busy_ready", 64'(fifo_ready), 64'(0));
    chk("busy_count", 64'(count), 64'(0));
    chk("busy_valid", 64'(rd_valid), 64'(0));
    chk("busy_ovf", 64'(overflow), 64'(0));
    for (int k = 1; k < 20; k++) begin
      fifo_reset = (k < 3);
      tick();
      chk("busy_wait_ready", 64'(fifo_ready), 64'(0));
    end
    dma_busy = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("busy_rel%0d_ready", k), 64'(fifo_ready), 64'(k == 5));
    end

    // Flush restart from FLUSH_HOLD, with writes hammering throughout
    wr_en = 1'b1;
    wr_data = 32'h5A5A;
    fifo_reset = 1'b1;
    tick();
    chk("rst_pulse_ready", 64'(fifo_ready), 64'(0));
    fifo_reset = 1'b0;
    tick();
    tick();
    chk("hold_ready", 64'(fifo_ready), 64'(0));
    fifo_reset = 1'b1;
    tick();
    fifo_reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("restart%0d_ready", k), 64'(fifo_ready), 64'(k == 5));
      chk("flush_wr_count", 64'(count), 64'(0));
      chk("flush_wr_ovf", 64'(overflow), 64'(0));
    end
    wr_en = 1'b0;

    // Mid-run reset with the DMA request raised
    for (int i = 0; i < BURST + 4; i++) wr(DW'(32'h1000 + i), 1'b1);
    chk("pre_rst_count", 64'(count), 64'(BURST + 4));
    chk("pre_rst_req", 64'(dma_req), 64'(1));
    chk("pre_rst_valid", 64'(rd_valid), 64'(1));
    reset_n = 1'b0;
    tick();
    sb.delete();
    chk_zero("midrst");
    reset_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
